cpu_mem_responder: RTL and testbench

//  Memory responder for the 8-bit CPU. It serves two initiator channels from one

---
 rtl/cpu_pkg.sv | 8 +
 rtl/mem_rr_arb.sv | 30 +++
 rtl/cpu_mem_responder.sv | 116 +++++++++++
 tb/tb_cpu_mem_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and types for the CPU memory responder
package cpu_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} mem_state_t;
  typedef enum logic {CH_IF, CH_D} chan_t;
endpackage

// File: rtl/mem_rr_arb.sv
// rtl/mem_rr_arb.sv - two-way round-robin arbiter between fetch and data channels
module mem_rr_arb
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output chan_t      grant
);
  chan_t last_grant;

  // req[0] is fetch, req[1] is data; on a tie the channel not granted last wins
  always_comb begin
    grant = CH_IF;
    if (req == 2'b10) begin
      grant = CH_D;
    end else if (req == 2'b11) begin
      grant = (last_grant == CH_IF) ? CH_D : CH_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= CH_IF;
    end else if (accept) begin
      last_grant <= grant;
    end
  end
endmodule

// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - shared storage serving fetch and load/store channels
module cpu_mem_responder #(
  parameter int ADDR_W      = cpu_pkg::ADDR_W,
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              busy
);
  import cpu_pkg::*;

  localparam int              IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

  mem_state_t        state, next_state;
  logic [3:0]        cnt;
  logic              accept;
  chan_t             gnt, lat_ch, rd_ch;
  logic              lat_we, rd_we;
  logic [ADDR_W-1:0] lat_addr, rd_addr;
  logic [DATA_W-1:0] lat_wdata, rd_word;
  logic [DATA_W-1:0] mem [DEPTH];

  mem_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({d_req, if_req}),
    .accept (accept),
    .grant  (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Acks are masked by rst so a transaction cut short by reset never reports completion
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    if_ack     = 1'b0;
    d_ack      = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          accept     = 1'b1;
          next_state = (WAIT_CYCLES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) next_state = ACK;
      end
      ACK: begin
        next_state = IDLE;
        if_ack     = (lat_ch == CH_IF) && !rst;
        d_ack      = (lat_ch == CH_D) && !rst;
      end
      default: next_state = IDLE;
    endcase
  end

  // With zero wait states the read happens on the accept edge, before the request is latched
  always_comb begin
    rd_ch   = (state == IDLE) ? gnt : lat_ch;
    rd_we   = (state == IDLE) ? (gnt == CH_D) && d_we : lat_we;
    rd_addr = (state == IDLE) ? ((gnt == CH_D) ? d_addr : if_addr) : lat_addr;
    rd_word = ({1'b0, rd_addr} < DEPTH_L) ? mem[rd_addr[IDX_W-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      lat_ch    <= CH_IF;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if (accept) begin
        cnt       <= WAIT_L;
        lat_ch    <= gnt;
        lat_we    <= (gnt == CH_D) && d_we;
        lat_addr  <= (gnt == CH_D) ? d_addr : if_addr;
        lat_wdata <= d_wdata;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (next_state == ACK && state != ACK) begin
        if (rd_ch == CH_IF)  if_rdata <= rd_word;
        else if (!rd_we)     d_rdata  <= rd_word;
      end
    end
  end

  // Storage is deliberately outside reset; a store only lands at the end of a clean ACK cycle
  always_ff @(posedge clk) begin
    if (!rst && state == ACK && lat_ch == CH_D && lat_we && ({1'b0, lat_addr} < DEPTH_L)) begin
      mem[lat_addr[IDX_W-1:0]] <= lat_wdata;
    end
  end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - self-checking bench for cpu_mem_responder over four configurations
module tb_cpu_mem_responder;
  logic clk;
  logic [3:0] rst, if_req, if_ack, d_req, d_we, d_ack, busy;
  logic [3:0][7:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;

  int checks = 0;
  int errors = 0;
  logic [7:0] mm [4][256];

  function automatic int wc(input int k);
    case (k)
      0: return 1;
      1: return 1;
      2: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int dp(input int k);
    return (k == 1) ? 128 : 256;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    cpu_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(dp(g)), .WAIT_CYCLES(wc(g))) u_dut (
      .clk(clk), .rst(rst[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_ack(d_ack[g]), .d_rdata(d_rdata[g]), .busy(busy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_store(input int k, input logic [7:0] a, input logic [7:0] v);
    if (int'(a) < dp(k)) mm[k][a] = v;
  endtask

  function automatic logic [7:0] model_read(input int k, input logic [7:0] a);
    return (int'(a) < dp(k)) ? mm[k][a] : 8'h00;
  endfunction

  task automatic wait_idle(input int k);
    @(negedge clk);
    for (int i = 0; i < 30 && busy[k]; i++) @(negedge clk);
  endtask

  // One transaction; returns ack-seen, edges from accept to ack, read data, and any foreign ack
  task automatic txn(input int k, input bit is_d, input bit we, input logic [7:0] addr,
                     input logic [7:0] wdata, output bit acked, output int lat,
                     output logic [7:0] rd, output bit clash);
    wait_idle(k);
    if (is_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    acked = 1'b0; lat = -1; rd = 8'h00; clash = 1'b0;
    @(posedge clk);
    #1;
    if (is_d) begin
      d_we[k] = 1'($urandom); d_addr[k] = 8'($urandom); d_wdata[k] = 8'($urandom);
    end else begin
      if_addr[k] = 8'($urandom);
    end
    for (int i = 0; i < 20; i++) begin
      if (is_d ? if_ack[k] : d_ack[k]) clash = 1'b1;
      if (is_d ? d_ack[k] : if_ack[k]) begin
        acked = 1'b1; lat = i; rd = is_d ? d_rdata[k] : if_rdata[k];
        break;
      end
      @(posedge clk);
      #1;
    end
    d_req[k] = 1'b0;
    if_req[k] = 1'b0;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({if_ack[k], d_ack[k], busy[k], if_rdata[k], d_rdata[k]} !== 19'd0) begin
        errors++;
        $display("FAIL reset dut%0d: ack/busy/rdata=%h expected 0", k,
                 {if_ack[k], d_ack[k], busy[k], if_rdata[k], d_rdata[k]});
      end
    end
  endtask

  task automatic test_fetch;
    bit a, c; int lat; logic [7:0] rd;
    txn(0, 1'b1, 1'b1, 8'h05, 8'hC8, a, lat, rd, c);
    model_store(0, 8'h05, 8'hC8);
    txn(0, 1'b0, 1'b0, 8'h05, 8'h00, a, lat, rd, c);
    checks++;
    if (a !== 1'b1 || lat != wc(0)) begin
      errors++; $display("FAIL fetch_latency: acked=%0b lat=%0d expected acked=1 lat=%0d", a, lat, wc(0));
    end
    checks++;
    if (rd !== model_read(0, 8'h05)) begin
      errors++; $display("FAIL fetch_data: got %h expected %h", rd, model_read(0, 8'h05));
    end
    checks++;
    if (c !== 1'b0) begin
      errors++; $display("FAIL fetch_no_d_ack: d_ack seen=%0b expected 0", c);
    end
    @(posedge clk);
    #1;
    checks++;
    if (if_ack[0] !== 1'b0 || if_rdata[0] !== 8'hC8) begin
      errors++; $display("FAIL fetch_pulse_hold: if_ack=%0b if_rdata=%h expected 0/c8", if_ack[0], if_rdata[0]);
    end
  endtask

  task automatic test_store_load;
    bit a, c; int lat; logic [7:0] rd;
    txn(0, 1'b1, 1'b1, 8'h10, 8'h5F, a, lat, rd, c);
    model_store(0, 8'h10, 8'h5F);
    @(posedge clk);
    #1;
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++; $display("FAIL store_load_idle_busy: busy=%0b expected 0", busy[0]);
    end
    txn(0, 1'b1, 1'b0, 8'h10, 8'h00, a, lat, rd, c);
    checks++;
    if (a !== 1'b1 || rd !== model_read(0, 8'h10)) begin
      errors++; $display("FAIL store_load_data: acked=%0b got %h expected %h", a, rd, model_read(0, 8'h10));
    end
  endtask

  task automatic test_contention;
    bit last_d, exp_d, seen_d, done;
    int n, overlap;
    @(negedge clk);
    rst[0] = 1'b1;
    if_req[0] = 1'b1; if_addr[0] = 8'h05;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h10;
    @(negedge clk);
    rst[0] = 1'b0;
    last_d = 1'b0; n = 0; overlap = 0;
    for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
      @(posedge clk);
      #1;
      if (if_ack[0] && d_ack[0]) overlap++;
      else if (if_ack[0] || d_ack[0]) begin
        exp_d = !last_d;
        last_d = exp_d;
        checks++;
        if (d_ack[0] !== exp_d) begin
          errors++; $display("FAIL contention_order%0d: d_ack=%0b expected %0b", n, d_ack[0], exp_d);
        end
        checks++;
        if ((exp_d ? d_rdata[0] : if_rdata[0]) !== model_read(0, exp_d ? 8'h10 : 8'h05)) begin
          errors++; $display("FAIL contention_data%0d: got %h expected %h", n,
                             exp_d ? d_rdata[0] : if_rdata[0], model_read(0, exp_d ? 8'h10 : 8'h05));
        end
        n++;
      end
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    checks++;
    if (n != 4 || overlap != 0) begin
      errors++; $display("FAIL contention_count: acks=%0d overlaps=%0d expected 4/0", n, overlap);
    end
    wait_idle(0);
    rst[0] = 1'b1;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 8'h07; d_wdata[0] = 8'hA5;
    if_req[0] = 1'b1; if_addr[0] = 8'h07;
    @(negedge clk);
    rst[0] = 1'b0;
    seen_d = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(posedge clk);
      #1;
      if (d_ack[0]) begin
        d_req[0] = 1'b0; seen_d = 1'b1; model_store(0, 8'h07, 8'hA5);
      end
      if (if_ack[0]) begin
        if_req[0] = 1'b0; done = 1'b1;
        checks++;
        if (seen_d !== 1'b1 || if_rdata[0] !== model_read(0, 8'h07)) begin
          errors++; $display("FAIL same_addr_fetch: store_first=%0b got %h expected 1/%h",
                             seen_d, if_rdata[0], model_read(0, 8'h07));
        end
      end
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL same_addr_timeout: fetch ack seen=%0b expected 1", done);
    end
  endtask

  task automatic test_unmapped;
    bit a, c; int lat; logic [7:0] rd;
    logic [7:0] addrs [5] = '{8'h7F, 8'h80, 8'h80, 8'h7F, 8'h80};
    bit         is_ds [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit         wes   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] wds   [5] = '{8'h3C, 8'h00, 8'hFF, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) begin
      txn(1, is_ds[i], wes[i], addrs[i], wds[i], a, lat, rd, c);
      checks++;
      if (a !== 1'b1) begin
        errors++; $display("FAIL unmapped_ack%0d: acked=%0b expected 1", i, a);
      end
      if (is_ds[i] && wes[i]) model_store(1, addrs[i], wds[i]);
      else begin
        checks++;
        if (rd !== model_read(1, addrs[i])) begin
          errors++; $display("FAIL unmapped_read%0d addr %h: got %h expected %h", i, addrs[i], rd, model_read(1, addrs[i]));
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    bit a, c, seen_ack, seen_busy; int lat; logic [7:0] rd;
    txn(2, 1'b1, 1'b1, 8'h30, 8'h11, a, lat, rd, c);
    model_store(2, 8'h30, 8'h11);
    for (int pass = 0; pass < 2; pass++) begin
      wait_idle(2);
      d_req[2] = 1'b1; d_we[2] = 1'b1; d_addr[2] = 8'h30; d_wdata[2] = (pass == 0) ? 8'h22 : 8'h33;
      @(posedge clk);
      repeat ((pass == 0) ? 1 : 3) @(posedge clk);
      #1;
      rst[2] = 1'b1; d_req[2] = 1'b0;
      #1;
      seen_ack = d_ack[2];
      @(posedge clk);
      #1;
      rst[2] = 1'b0;
      checks++;
      if (d_rdata[2] !== 8'h00) begin
        errors++; $display("FAIL reset_mid%0d_rdata: got %h expected 00", pass, d_rdata[2]);
      end
      seen_busy = 1'b0;
      for (int i = 0; i < 6; i++) begin
        seen_ack |= d_ack[2];
        seen_busy |= busy[2];
        @(posedge clk);
        #1;
      end
      checks++;
      if (seen_ack !== 1'b0 || seen_busy !== 1'b0) begin
        errors++; $display("FAIL reset_mid%0d_idle: d_ack seen=%0b busy seen=%0b expected 0/0", pass, seen_ack, seen_busy);
      end
      txn(2, 1'b1, 1'b0, 8'h30, 8'h00, a, lat, rd, c);
      checks++;
      if (a !== 1'b1 || rd !== model_read(2, 8'h30)) begin
        errors++; $display("FAIL reset_mid%0d_store_dropped: got %h expected %h", pass, rd, model_read(2, 8'h30));
      end
    end
  endtask

  task automatic test_back_to_back;
    bit a, c; int lat, n, prev; logic [7:0] rd, v;
    for (int i = 0; i < 4; i++) begin
      v = 8'($urandom);
      txn(3, 1'b1, 1'b1, 8'(i), v, a, lat, rd, c);
      model_store(3, 8'(i), v);
    end
    wait_idle(3);
    if_req[3] = 1'b1; if_addr[3] = 8'h00;
    n = 0; prev = 0;
    for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
      @(posedge clk);
      #1;
      if (if_ack[3]) begin
        checks++;
        if (if_rdata[3] !== model_read(3, 8'(n))) begin
          errors++; $display("FAIL b2b_data%0d: got %h expected %h", n, if_rdata[3], model_read(3, 8'(n)));
        end
        if (n > 0) begin
          checks++;
          if (cyc - prev != wc(3) + 2) begin
            errors++; $display("FAIL b2b_interval%0d: got %0d expected %0d", n, cyc - prev, wc(3) + 2);
          end
        end
        prev = cyc;
        n++;
        if_addr[3] = 8'(n);
        if (n == 4) if_req[3] = 1'b0;
      end
    end
    if_req[3] = 1'b0;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL b2b_count: acks=%0d expected 4", n);
    end
  endtask

  task automatic test_random;
    bit a, c, is_d, we; int lat; logic [7:0] rd, addr, v;
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom);
      txn(0, 1'b1, 1'b1, 8'h40 + 8'(i), v, a, lat, rd, c);
      model_store(0, 8'h40 + 8'(i), v);
    end
    for (int i = 0; i < 30; i++) begin
      is_d = 1'($urandom); we = is_d && 1'($urandom);
      addr = 8'h40 + 8'($urandom_range(0, 15)); v = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      txn(0, is_d, we, addr, v, a, lat, rd, c);
      checks++;
      if (a !== 1'b1 || lat != wc(0) || c !== 1'b0) begin
        errors++; $display("FAIL random%0d_handshake: acked=%0b lat=%0d clash=%0b expected 1/%0d/0", i, a, lat, c, wc(0));
      end
      if (we) model_store(0, addr, v);
      else begin
        checks++;
        if (rd !== model_read(0, addr)) begin
          errors++; $display("FAIL random%0d_data ch=%0b addr %h: got %h expected %h", i, is_d, addr, rd, model_read(0, addr));
        end
      end
    end
  endtask

  initial begin
    rst = 4'hF; if_req = '0; d_req = '0; d_we = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 4'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_fetch();
    test_store_load();
    test_contention();
    test_unmapped();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
